register_file_32x32: RTL and testbench
======================================

// Module: register_file_32x32
// PURPOSE
//   32-entry register file, 2 read ports and 1 write port. Sits directly downstream of DECODER_5x32.
//   The write address is decoded by an instance of DECODER_5x32. Its one-hot 32-bit output,
//   ANDed with WRITE, forms the per-register load enables.
//   Read ports are registered and feed the datapath/ALU operand latches.
// PARAMETERS
//   DATA_WIDTH   32   width of each register and of all data ports
//   RESET_VALUE  0    value loaded into R1..R31 on reset (R0 is always 0)
// PORTS
//   CLK      in   1           clock; all state updates on rising edge
//   RST      in   1           synchronous reset, active-high
//   WRITE    in   1           write strobe; DATA_W loaded into reg ADDR_W at this edge
//   ADDR_W   in   5           write address; drives I of internal DECODER_5x32
//   DATA_W   in   DATA_WIDTH  write data
//   READ     in   1           read strobe; both read ports sampled at this edge
//   ADDR_R1  in   5           read port 1 address
//   ADDR_R2  in   5           read port 2 address
//   DATA_R1  out  DATA_WIDTH  registered read data, port 1
//   DATA_R2  out  DATA_WIDTH  registered read data, port 2
// BEHAVIOUR
//   - Clock/reset: single clock CLK; RST synchronous, active-high.
//     RST dominates WRITE and READ in the same cycle.
//   - Reset: R0=0, R1..R31=RESET_VALUE, DATA_R1=DATA_R2=0 after the first CLK edge with RST=1.
//     A reset mid-write discards that write.
//   - Write: load_en[i] = WRITE & D[i], where D is the DECODER_5x32 output for ADDR_W.
//     Exactly one register updates per write edge. The new value is visible to reads
//     sampled on the following edge.
//   - R0 hardwired: writes to ADDR_W=0 are ignored; reads of address 0 always return 0.
//   - Read: READ=1 at an edge -> DATA_R1 <= reg[ADDR_R1] and DATA_R2 <= reg[ADDR_R2].
//     Data is valid 1 cycle after the strobe.
//   - READ=0: DATA_R1/DATA_R2 hold their last value (no change).
//   - Dual read: ADDR_R1==ADDR_R2 is legal; both ports return the same value.
//   - Read/write collision (READ & WRITE, ADDR_Rx==ADDR_W!=0, same edge):
//     DATA_Rx returns the OLD register content (read-before-write), unless RF_BYPASS_EN is set.
//   - No X propagation: all storage is reset; unknown addresses are not possible (5-bit full decode).
//   - Widths: no arithmetic. Addresses are full 5-bit, so there is no wrap or out-of-range case.
// CONFIGURATION
//   RF_BYPASS_EN (`define) -- write-to-read forwarding.
//     Defined: on a collision, DATA_Rx <= DATA_W (new value) in that same edge.
//       Applies per port independently; never applies to address 0 (still returns 0).
//     Undefined: read-before-write as above.
//       Adds no logic beyond the base mux tree.
// TESTING
//   1 Reset: write R1..R31 nonzero, RST=1 one cycle, READ all pairs
//     -> R1..R31=RESET_VALUE, R0=0, DATA_R1/R2=0 right after reset.
//   2 Decode sweep: for A=0..31, WRITE A<=32'hA5A5_0000|A, then READ R1=A, R2=31-A
//     -> DATA_R1=written value (0 for A=0); no other register disturbed.
//   3 R0 protection: WRITE ADDR_W=0 DATA_W=32'hFFFF_FFFF, READ ADDR_R1=0 -> DATA_R1=0.
//   4 Collision: R5=32'h1111_1111; same edge WRITE R5<=32'h2222_2222, READ R1=R2=5.
//     -> DATA_R1=DATA_R2=32'h1111_1111 (32'h2222_2222 with RF_BYPASS_EN).
//     -> Next READ of R5 gives 32'h2222_2222 in both builds.
//   5 Hold: READ R1=3 (R3=32'hDEAD_BEEF), then READ=0 for 4 cycles while ADDR_R1 changes
//     -> DATA_R1 stays 32'hDEAD_BEEF.
//   6 Reset priority: WRITE R7<=32'h1234_5678 with RST=1 same edge, READ R7 next
//     -> DATA_R1=RESET_VALUE.

Source files
------------

// File: rtl/register_file_32x32.sv
// 32x32 register file: one write port (address decoded by DECODER_5x32), two registered read ports.
// Optional macro RF_BYPASS_EN forwards DATA_W to a read port that collides with the write address.

module DECODER_5x32 (
    input  logic [4:0]  I,
    output logic [31:0] D
);
    always_comb begin
        D    = '0;
        D[I] = 1'b1;
    end
endmodule

module register_file_32x32 #(
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WRITE,
    input  logic [4:0]            ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  READ,
    input  logic [4:0]            ADDR_R1,
    input  logic [4:0]            ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);
    logic [31:0]           w_dec;
    logic [31:0]           w_load_en;
    logic [DATA_WIDTH-1:0] r_regs [32];
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    DECODER_5x32 u_wdec (
        .I (ADDR_W),
        .D (w_dec)
    );

    assign w_load_en = w_dec & {32{WRITE}};

    // Entry 0 is held at zero; its load enable is deliberately ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= (i == 0) ? '0 : RESET_VALUE;
            end
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (w_load_en[i] && (i != 0)) begin
                    r_regs[i] <= DATA_W;
                end
            end
        end
    end

    always_comb begin
        w_rd1 = (ADDR_R1 == 5'd0) ? '0 : r_regs[ADDR_R1];
        w_rd2 = (ADDR_R2 == 5'd0) ? '0 : r_regs[ADDR_R2];
`ifdef RF_BYPASS_EN
        if (WRITE && (ADDR_W != 5'd0) && (ADDR_W == ADDR_R1)) begin
            w_rd1 = DATA_W;
        end
        if (WRITE && (ADDR_W != 5'd0) && (ADDR_W == ADDR_R2)) begin
            w_rd2 = DATA_W;
        end
`else
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ) begin
            DATA_R1 <= w_rd1;
            DATA_R2 <= w_rd2;
        end
    end
endmodule

// File: tb/tb_register_file_32x32.sv
// Directed self-checking bench for register_file_32x32 (honours RF_BYPASS_EN when defined).

module tb_register_file_32x32;
    localparam logic [31:0] RV = 32'h5A5A_0F0F;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        WRITE;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        READ;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [32];

    register_file_32x32 #(
        .DATA_WIDTH  (32),
        .RESET_VALUE (RV)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WRITE   (WRITE),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ    (READ),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        WRITE = 1'b1; ADDR_W = a; DATA_W = d;
        tick();
        WRITE = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        READ = 1'b1; ADDR_R1 = a1; ADDR_R2 = a2;
        tick();
        READ = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hC0DE_0000 | 32'(i));
        do_read(5'd1, 5'd2);
        n_checks++;
        if (DATA_R1 !== 32'hC0DE_0001) begin
            n_fail++; $display("FAIL pre_reset_r1: got %h expected %h", DATA_R1, 32'hC0DE_0001);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = (i == 0) ? 32'h0 : RV;
        n_checks++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%h expected 0/0", DATA_R1, DATA_R2);
        end
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i));
            n_checks++;
            if (DATA_R1 !== ((i == 0) ? 32'h0 : RV) || DATA_R2 !== ((i == 31) ? 32'h0 : RV)) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h/%h expected %h/%h", i, DATA_R1, DATA_R2,
                         (i == 0) ? 32'h0 : RV, (i == 31) ? 32'h0 : RV);
            end
        end
    endtask

    task automatic test_decode_sweep();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int a = 0; a < 32; a++) begin
            do_write(5'(a), 32'hA5A5_0000 | 32'(a));
            do_read(5'(a), 5'(31 - a));
            e1 = (a == 0) ? 32'h0 : (32'hA5A5_0000 | 32'(a));
            e2 = ((31 - a) == 0) ? 32'h0 : ((31 - a) <= a ? (32'hA5A5_0000 | 32'(31 - a)) : RV);
            n_checks++;
            if (DATA_R1 !== e1 || DATA_R2 !== e2) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %h/%h expected %h/%h", a, DATA_R1, DATA_R2, e1, e2);
            end
        end
        for (int a = 0; a < 32; a += 2) begin
            do_read(5'(a), 5'(a + 1));
            n_checks++;
            if (DATA_R1 !== mdl[a] || DATA_R2 !== mdl[a + 1]) begin
                n_fail++;
                $display("FAIL sweep_readback[%0d]: got %h/%h expected %h/%h", a, DATA_R1, DATA_R2,
                         mdl[a], mdl[a + 1]);
            end
        end
    endtask

    task automatic test_r0_protect();
        do_write(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd0);
        n_checks++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0) begin
            n_fail++; $display("FAIL r0_protect: got %h/%h expected 0/0", DATA_R1, DATA_R2);
        end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        do_write(5'd5, 32'h1111_1111);
        WRITE = 1'b1; ADDR_W = 5'd5; DATA_W = 32'h2222_2222;
        READ = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd5;
        tick();
        WRITE = 1'b0; READ = 1'b0; mdl[5] = 32'h2222_2222;
        e = BYP ? 32'h2222_2222 : 32'h1111_1111;
        n_checks++;
        if (DATA_R1 !== e || DATA_R2 !== e) begin
            n_fail++; $display("FAIL collision_same: got %h/%h expected %h/%h", DATA_R1, DATA_R2, e, e);
        end
        do_read(5'd5, 5'd5);
        n_checks++;
        if (DATA_R1 !== 32'h2222_2222 || DATA_R2 !== 32'h2222_2222) begin
            n_fail++; $display("FAIL collision_after: got %h/%h expected 22222222/22222222", DATA_R1, DATA_R2);
        end
        // Collision on port 2 only.
        WRITE = 1'b1; ADDR_W = 5'd6; DATA_W = 32'h3333_3333;
        READ = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd6;
        tick();
        WRITE = 1'b0; READ = 1'b0;
        e = BYP ? 32'h3333_3333 : 32'hA5A5_0006;
        mdl[6] = 32'h3333_3333;
        n_checks++;
        if (DATA_R1 !== 32'h2222_2222 || DATA_R2 !== e) begin
            n_fail++; $display("FAIL collision_port2: got %h/%h expected 22222222/%h", DATA_R1, DATA_R2, e);
        end
        // Address 0 never forwards.
        WRITE = 1'b1; ADDR_W = 5'd0; DATA_W = 32'h4444_4444;
        READ = 1'b1; ADDR_R1 = 5'd0; ADDR_R2 = 5'd0;
        tick();
        WRITE = 1'b0; READ = 1'b0;
        n_checks++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0) begin
            n_fail++; $display("FAIL collision_r0: got %h/%h expected 0/0", DATA_R1, DATA_R2);
        end
    endtask

    task automatic test_hold();
        do_write(5'd3, 32'hDEAD_BEEF);
        do_read(5'd3, 5'd6);
        for (int k = 0; k < 4; k++) begin
            ADDR_R1 = 5'(10 + k);
            ADDR_R2 = 5'(20 + k);
            tick();
            n_checks++;
            if (DATA_R1 !== 32'hDEAD_BEEF || DATA_R2 !== 32'h3333_3333) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h/%h expected deadbeef/33333333", k, DATA_R1, DATA_R2);
            end
        end
    endtask

    task automatic test_reset_priority();
        RST = 1'b1;
        WRITE = 1'b1; ADDR_W = 5'd7; DATA_W = 32'h1234_5678;
        READ = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd3;
        tick();
        RST = 1'b0; WRITE = 1'b0; READ = 1'b0;
        n_checks++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0) begin
            n_fail++; $display("FAIL rst_prio_outputs: got %h/%h expected 0/0", DATA_R1, DATA_R2);
        end
        do_read(5'd7, 5'd3);
        n_checks++;
        if (DATA_R1 !== RV || DATA_R2 !== RV) begin
            n_fail++; $display("FAIL rst_prio_read: got %h/%h expected %h/%h", DATA_R1, DATA_R2, RV, RV);
        end
    endtask

    initial begin
        RST = 1'b1; WRITE = 1'b0; ADDR_W = '0; DATA_W = '0;
        READ = 1'b0; ADDR_R1 = '0; ADDR_R2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        tick();
        tick();
        RST = 1'b0;
        test_reset();
        test_decode_sweep();
        test_r0_protect();
        test_collision();
        test_hold();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
